contour_coord_streamer: RTL and testbench
=========================================

Name: contour_coord_streamer

Overview:
- Consumer at the far end of the 26x18 contour mesh.
- Captures the 468-bit contour bitmap produced by the mesh and converts it into a stream of (x, y) coordinates, one per set contour pixel.
- Coordinates are emitted in raster order over a valid/ready handshake, so downstream logic (UART/DMA/chain-code stage) can read the contour serially instead of as a wide bus.

Parameters:
- COLS, 26, pixels per row (x range 0..COLS-1).
- ROWS, 18, rows per frame (y range 0..ROWS-1).
- Derived widths: NPIX = COLS*ROWS = 468; XW = 5; YW = 5; CW = 9 (count width, holds 0..468).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle request to capture contour_in and begin a scan; sampled only in IDLE.
- contour_in  in  NPIX  contour bitmap; bit index = y*COLS + x; bit 0 = (x0, y0).
- busy  out  1  high in every state except IDLE.
- out_valid  out  1  coordinate beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_x  out  XW  column of the contour pixel.
- out_y  out  YW  row of the contour pixel.
- out_eof  out  1  end-of-frame sentinel flag (see Optional Feature).
- count  out  CW  number of coordinate beats accepted in the current/last frame.
- done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset: state IDLE; busy, out_valid, out_eof, done = 0; out_x, out_y, count = 0; scan index/x/y counters = 0.
  - rst has priority over all other inputs in any state, including mid-EMIT.
  - The shadow bitmap need not be cleared.
- All outputs are registered.
- States: IDLE, SCAN, EMIT, EOF (only with macro), DONE.
- IDLE:
  - On start=1 at edge E0: shadow <= contour_in, idx/x/y <= 0, count <= 0, go to SCAN.
  - contour_in is ignored at all other times.
- SCAN: one pixel is examined per cycle at index idx (x, y tracked alongside; x wraps at COLS-1 to 0 and y increments).
  - If shadow[idx]=1: out_x <= x, out_y <= y, out_valid <= 1, go to EMIT.
  - If shadow[idx]=0 and idx < NPIX-1: advance idx.
  - If shadow[idx]=0 and idx = NPIX-1: end of frame.
- EMIT:
  - out_x/out_y/out_valid are held stable while out_ready=0, with no timeout.
  - On out_valid & out_ready at an edge: out_valid <= 0, count <= count+1.
  - Then, if idx = NPIX-1: end of frame; else advance idx and go to SCAN.
- End of frame: go to DONE with done <= 1 (or to EOF with the macro).
- DONE: done is high for exactly one cycle; next edge goes to IDLE, done <= 0.
- Timing:
  - Pixel 0 set: out_valid is first seen high after edge E1.
  - Empty bitmap: edges E1..E468 scan indices 0..467; done is high in the cycle after E468; IDLE after E469.
  - Each emitted pixel costs one SCAN cycle plus at least one EMIT cycle.
- start asserted while busy=1 is ignored; no queuing.
- out_ready sampled while out_valid=0 has no effect.
- count holds its final value after done until the next accepted start.
- Max count = 468 (all bits set); no overflow is possible at CW=9.

Optional Feature:
- Macro: CONTOUR_EOF_EN.
- Defined: end of frame goes to state EOF.
  - EOF drives out_valid=1, out_eof=1, out_x=5'h1F, out_y=5'h1F.
  - The beat holds until out_ready; on handshake, out_valid/out_eof <= 0 and go to DONE.
  - The sentinel does not increment count. An empty frame produces only the sentinel beat.
- Undefined: the EOF state is not built, out_eof is tied 0, and end of frame goes directly to DONE.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> all outputs 0, busy=0. Assert rst during EMIT -> out_valid=0 and busy=0 on the next cycle.
- Single pixel: contour_in = 1 << 0, start, out_ready=1 -> exactly one beat (x=0, y=0) after E1, count=1, done pulses once, busy low afterward.
- Corner pixels: bits 25, 26 and 467 set, out_ready=1 -> beats (25,0), (0,1), (25,17) in that order; count=3.
- Empty frame: contour_in=0, start -> no out_valid (macro off), done high in the cycle after E468, count=0. With CONTOUR_EOF_EN -> single beat (31,31), out_eof=1, count=0.
- Backpressure: bits 3 and 30 set, out_ready=0 for 10 cycles after the first valid -> out_x=3, out_y=0 held stable for all 10 cycles; then (4,1) follows after the handshake; count=2.
- Restart and full frame: start pulsed mid-scan is ignored. Then all 468 bits set with out_ready toggling 1/0 each cycle -> 468 beats in raster order, count=468; a new start after done captures a fresh bitmap.

Source files
------------

// File: rtl/contour_coord_streamer.sv
// contour_coord_streamer: captures the COLS x ROWS contour bitmap on start and streams one (x, y) beat per set pixel in raster order.
// Latency: first beat is valid one cycle after the start edge when pixel 0 is set; each pixel costs one cycle, each set pixel one more.
// Backpressure: out_valid/out_x/out_y hold indefinitely while out_ready is low; the scan stalls until the beat is accepted.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             capture contour_in and begin a scan (IDLE only)
//   contour_in        bitmap, bit y*COLS + x is pixel (x, y)
//   busy              high in every state except IDLE
//   out_valid/ready   coordinate beat handshake; out_x/out_y carry the pixel
//   out_eof           end-of-frame sentinel beat (only when CONTOUR_EOF_EN is defined, else tied 0)
//   count             beats accepted in the current/last frame
//   done              one-cycle pulse at end of frame
//
// Build option: define CONTOUR_EOF_EN to append a sentinel beat (x=y=all ones, out_eof=1)
// after the last coordinate of every frame.
module contour_coord_streamer #(
    parameter int COLS = 26,
    parameter int ROWS = 18,
    parameter int NPIX = COLS * ROWS,
    parameter int XW   = $clog2(COLS),
    parameter int YW   = $clog2(ROWS),
    parameter int CW   = $clog2(NPIX + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [NPIX-1:0] contour_in,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XW-1:0]   out_x,
    output logic [YW-1:0]   out_y,
    output logic            out_eof,
    output logic [CW-1:0]   count,
    output logic            done
);

    localparam int IW = $clog2(NPIX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_EMIT,
        S_EOF,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [CW-1:0]   count_q, count_d;
    logic            busy_q, busy_d;
    logic            out_valid_q, out_valid_d;
    logic [XW-1:0]   out_x_q, out_x_d;
    logic [YW-1:0]   out_y_q, out_y_d;
    logic            done_q, done_d;
    logic [NPIX-1:0] shadow_q;

    logic last_pix;
    logic end_of_frame;
    logic advance;

`ifdef CONTOUR_EOF_EN
    logic out_eof_q, out_eof_d;
`endif

    assign last_pix = (idx_q == IW'(NPIX - 1));

    // Bitmap snapshot: only the start edge in IDLE loads it, so the mesh
    // is free to change contour_in while the frame is streamed out.
    always_ff @(posedge clk) begin
        if (!rst && state_q == S_IDLE && start) begin
            shadow_q <= contour_in;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        x_d          = x_q;
        y_d          = y_q;
        count_d      = count_q;
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        done_d       = 1'b0;
        end_of_frame = 1'b0;
        advance      = 1'b0;
`ifdef CONTOUR_EOF_EN
        out_eof_d    = out_eof_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_SCAN;
                    idx_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    count_d = '0;
                end
            end

            S_SCAN: begin
                if (shadow_q[idx_q]) begin
                    out_x_d     = x_q;
                    out_y_d     = y_q;
                    out_valid_d = 1'b1;
                    state_d     = S_EMIT;
                end else if (last_pix) begin
                    end_of_frame = 1'b1;
                end else begin
                    advance = 1'b1;
                end
            end

            S_EMIT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = count_q + 1'b1;
                    if (last_pix) begin
                        end_of_frame = 1'b1;
                    end else begin
                        advance = 1'b1;
                        state_d = S_SCAN;
                    end
                end
            end

`ifdef CONTOUR_EOF_EN
            S_EOF: begin
                // Sentinel beat is not a pixel, so count is left alone.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_eof_d   = 1'b0;
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                end
            end
`endif

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (end_of_frame) begin
`ifdef CONTOUR_EOF_EN
            state_d     = S_EOF;
            out_valid_d = 1'b1;
            out_eof_d   = 1'b1;
            out_x_d     = '1;
            out_y_d     = '1;
`else
            state_d     = S_DONE;
            done_d      = 1'b1;
`endif
        end

        // x/y follow idx so no divide is needed to recover coordinates.
        if (advance) begin
            idx_d = idx_q + 1'b1;
            if (x_q == XW'(COLS - 1)) begin
                x_d = '0;
                y_d = y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            done_q      <= 1'b0;
`ifdef CONTOUR_EOF_EN
            out_eof_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_y_q     <= out_y_d;
            done_q      <= done_d;
`ifdef CONTOUR_EOF_EN
            out_eof_q   <= out_eof_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign count     = count_q;
    assign done      = done_q;
`ifdef CONTOUR_EOF_EN
    assign out_eof   = out_eof_q;
`else
    assign out_eof   = 1'b0;
`endif

endmodule

// File: tb/tb_contour_coord_streamer.sv
// Directed bench for contour_coord_streamer: reset, single/corner pixels,
// empty frame, backpressure, ignored restart, full frame with toggling ready.
module tb_contour_coord_streamer;
    localparam int COLS = 26;
    localparam int ROWS = 18;
    localparam int NPIX = COLS * ROWS;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [NPIX-1:0] contour_in;
    logic            busy;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_x;
    logic [4:0]      out_y;
    logic            out_eof;
    logic [8:0]      count;
    logic            done;

    int tests = 0;
    int fails = 0;

    logic [10:0] beats[$];
    logic [10:0] exp_q[$];
    int done_cnt;
    int done_cyc;
    int first_vld_cyc;

    always #5 clk = ~clk;

    contour_coord_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .contour_in (contour_in),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_eof    (out_eof),
        .count      (count),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] beat(input int x, input int y);
        return {1'b0, 5'(y), 5'(x)};
    endfunction

    // Starts a frame and collects accepted beats until done has pulsed and
    // busy has dropped. mode 0: ready always high; mode 1: ready toggles.
    // A second start with an all-ones bitmap is pulsed at cycle 'glitch'.
    task automatic run_frame(input string tag, input logic [NPIX-1:0] bm,
                             input int mode, input int glitch, input int max_cyc);
        logic finished;
        finished = 1'b0;
        beats.delete();
        done_cnt = 0;
        done_cyc = -1;
        first_vld_cyc = -1;
        contour_in = bm;
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        contour_in = ~bm;
        for (int k = 0; k < max_cyc; k++) begin
            if (k == glitch) begin
                start = 1'b1;
                contour_in = '1;
            end else begin
                start = 1'b0;
            end
            out_ready = (mode == 0) ? 1'b1 : ((k % 2) == 1);
            if (out_valid && first_vld_cyc < 0) first_vld_cyc = k;
            if (out_valid && out_ready) beats.push_back({out_eof, out_y, out_x});
            if (done) begin
                done_cnt++;
                done_cyc = k;
            end
            if (done_cyc >= 0 && !busy) begin
                finished = 1'b1;
                break;
            end
            tick();
        end
        start = 1'b0;
        out_ready = 1'b0;
        chk({tag, "_finished"}, {31'b0, finished}, 32'd1);
        chk({tag, "_done_pulses"}, done_cnt, 32'd1);
    endtask

    // Compares collected beats with exp_q (sentinel appended when enabled).
    task automatic check_beats(input string tag);
`ifdef CONTOUR_EOF_EN
        exp_q.push_back({1'b1, 5'h1F, 5'h1F});
`endif
        chk({tag, "_nbeats"}, beats.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < beats.size(); i++) begin
            chk($sformatf("%s_beat%0d", tag, i), {21'b0, beats[i]}, {21'b0, exp_q[i]});
        end
        exp_q.delete();
    endtask

    initial begin
        logic [NPIX-1:0] bm;
        logic got;

        // Reset with random inputs.
        rst = 1'b1;
        start = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        for (int i = 0; i < NPIX; i++) contour_in[i] = 1'($urandom_range(0, 1));
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_eof", out_eof, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b0;
        tick();

        // Reset while a beat is pending.
        bm = '0;
        bm[5] = 1'b1;
        contour_in = bm;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50 && !out_valid; k++) tick();
        chk("emitrst_valid_before", out_valid, 1);
        rst = 1'b1;
        tick();
        chk("emitrst_valid", out_valid, 0);
        chk("emitrst_busy", busy, 0);
        rst = 1'b0;
        tick();
        chk("emitrst_stays_idle", busy, 0);

        // Single pixel at (0,0).
        bm = '0;
        bm[0] = 1'b1;
        run_frame("single", bm, 0, -1, 1000);
        chk("single_first_valid_cycle", first_vld_cyc, 1);
        exp_q.push_back(beat(0, 0));
        check_beats("single");
        chk("single_count", count, 1);
        tick();
        chk("single_busy_after", busy, 0);
        chk("single_done_after", done, 0);

        // Row-end, row-start and last pixels.
        bm = '0;
        bm[25] = 1'b1;
        bm[26] = 1'b1;
        bm[467] = 1'b1;
        run_frame("corner", bm, 0, -1, 1000);
        exp_q.push_back(beat(25, 0));
        exp_q.push_back(beat(0, 1));
        exp_q.push_back(beat(25, 17));
        check_beats("corner");
        chk("corner_count", count, 3);

        // Empty frame.
        run_frame("empty", '0, 0, -1, 1000);
`ifdef CONTOUR_EOF_EN
        chk("empty_done_cycle", done_cyc, 469);
        chk("empty_first_valid_cycle", first_vld_cyc, 468);
`else
        chk("empty_done_cycle", done_cyc, 468);
        chk("empty_first_valid_cycle", first_vld_cyc, -1);
`endif
        check_beats("empty");
        chk("empty_count", count, 0);

        // Backpressure: bits 3 and 30, ready low for 10 cycles.
        bm = '0;
        bm[3] = 1'b1;
        bm[30] = 1'b1;
        contour_in = bm;
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 50 && !out_valid; k++) tick();
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("bp_hold_valid%0d", k), out_valid, 1);
            chk($sformatf("bp_hold_x%0d", k), out_x, 3);
            chk($sformatf("bp_hold_y%0d", k), out_y, 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_valid_dropped", out_valid, 0);
        chk("bp_count1", count, 1);
        for (int k = 0; k < 100 && !out_valid; k++) tick();
        chk("bp_second_valid", out_valid, 1);
        chk("bp_second_x", out_x, 4);
        chk("bp_second_y", out_y, 1);
        out_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (!busy) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        out_ready = 1'b0;
        chk("bp_finished", {31'b0, got}, 32'd1);
        chk("bp_count", count, 2);

        // Start pulsed mid-scan with an all-ones bitmap is ignored.
        bm = '0;
        bm[100] = 1'b1;
        run_frame("restart", bm, 0, 10, 1000);
        exp_q.push_back(beat(22, 3));
        check_beats("restart");
        chk("restart_count", count, 1);

        // Full frame with toggling ready.
        run_frame("full", '1, 1, -1, 4000);
        for (int i = 0; i < NPIX; i++) exp_q.push_back(beat(i % COLS, i / COLS));
        check_beats("full");
        chk("full_count", count, 468);
        tick();
        tick();
        chk("full_count_held", count, 468);

        // Fresh start captures a new bitmap.
        bm = '0;
        bm[27] = 1'b1;
        run_frame("fresh", bm, 0, -1, 1000);
        exp_q.push_back(beat(1, 1));
        check_beats("fresh");
        chk("fresh_count", count, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
